store_buffer_ext: RTL
=====================

Name: store_buffer_ext

Overview:
Parametrised successor to the M-stage store-alignment/byte-enable logic. Checks each store for an address exception (AdES). Aligns legal stores into bus lanes, generates byte enables, and queues them in a DEPTH-entry FIFO. The FIFO drains to the data-memory/peripheral bus over a valid/ready handshake, so the pipeline no longer waits on slow bus slaves. It sits between the M stage and the external data bus.

Parameters:
DATA_W, 32, bus data width in bits; 32 or 64.
DEPTH, 4, store FIFO entries; power of two, at least 2.
DM_START, 32'h0000_0000, first byte address of data memory.
DM_END, 32'h0000_2FFF, last byte address of data memory.
TC1_START, 32'h0000_7F00, timer 1 base; valid word offsets are 0..8.
TC2_START, 32'h0000_7F10, timer 2 base; valid word offsets are 0..8.
INT_START, 32'h0000_7F20, interrupt-ack region start.
INT_END, 32'h0000_7F23, interrupt-ack region end.

Ports:
clk  in  1  clock.
reset  in  1  asynchronous, active-low reset.
in_valid  in  1  M stage presents a store this cycle.
in_addr  in  32  store byte address (ALU result).
in_data  in  DATA_W  store data, right-justified.
in_size  in  2  00 word, 01 half, 10 byte, 11 dword (dword legal only when DATA_W=64).
in_add_ovf  in  1  address-add overflow from the ALU.
int_req  in  1  interrupt/exception taken this cycle; kills the incoming store.
stall  out  1  FIFO full; the M-stage store must be held.
ades  out  1  address-error-on-store, combinational.
m_valid  out  1  bus request valid.
m_ready  in  1  bus accepts the head entry.
m_addr  out  32  in_addr with the low log2(DATA_W/8) bits cleared.
m_wdata  out  DATA_W  lane-aligned data.
m_byteen  out  DATA_W/8  byte enables.
empty  out  1  no stores pending; used by syscall/eret fences.

Behaviour:
- ades = in_valid & (misaligned | out_of_range | timer_nonword | illegal_size | in_add_ovf). Same-cycle combinational output.
- misaligned: half with addr[0] set, word with addr[1:0] nonzero, or dword with addr[2:0] nonzero.
- out_of_range: address outside all of DM range, TC1 words, TC2 words and INT range. The TC windows end at base+8 inclusive.
- timer_nonword: size not word while the address is inside a TC window.
- illegal_size: size 11 while DATA_W=32.
- lane = addr[log2(DATA_W/8)-1:0].
- wdata is in_data shifted left by 8*lane, with the size-width field zero-extended.
- byteen is a contiguous mask of size bytes, shifted left by lane.
- enq = in_valid & ~ades & ~int_req & ~stall. The entry is written at the clock edge.
- A store with ades or int_req is dropped and never enqueued. Entries already queued are never flushed by int_req; committed stores must complete.
- stall = (count == DEPTH). Stall is asserted even if a dequeue happens in the same cycle (no bypass when full).
- deq = m_valid & m_ready.
- m_valid = (count != 0). m_addr, m_wdata and m_byteen come straight from the head entry (registered storage). The payload is stable while m_valid & ~m_ready.
- Simultaneous enq and deq: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. count runs from 0 to DEPTH.
- Minimum latency is 1 cycle: a store accepted at edge N has m_valid high after edge N when the FIFO was empty.
- Order is strictly FIFO; the bus sees stores in program order.
- empty = (count == 0).
- Reset (reset low, asynchronous) forces:
  - pointers and count to 0;
  - m_valid 0, m_byteen 0, m_wdata 0, m_addr 0, empty 1, stall 0.
- Reset asserted mid-transfer discards all queued entries. The bus must not see m_valid for 1 cycle after release.
- When m_valid is 0, m_byteen reads as all zero.

Test Plan:
- DATA_W=32, store byte 0xAB at addr 0x0000_0003, m_ready=1 -> next cycle m_valid=1, m_addr=0x0000_0000, m_byteen=4'b1000, m_wdata=0xAB00_0000.
- Half store at 0x0000_0001 -> ades=1 same cycle, nothing enqueued, empty stays 1. Byte store at 0x0000_7F04 -> ades=1 (timer_nonword). Word at 0x0000_7F08 -> accepted.
- m_ready=0 and 4 word stores 0x10..0x1C (DEPTH=4) -> stall=1 after the 4th. A 5th store is held. Raise m_ready -> drain order 0x10,0x14,0x18,0x1C with the 5th accepted once count<4.
- int_req=1 together with a valid store while 2 entries are queued -> the new store is dropped and the 2 queued entries still drain, followed by empty=1.
- DATA_W=64, dword 0x1122_3344_5566_7788 at addr 0x0000_0008 -> m_byteen=8'hFF, m_addr=0x0000_0008. Same store at 0x0000_000C -> ades=1.
- Assert reset low with 3 entries queued and m_valid=1 -> all outputs at reset values immediately. After release m_valid=0 and empty=1.

Source files
------------

// File: rtl/store_buffer_ext.sv
// store_buffer_ext: M-stage store checker, aligner and store FIFO.
//   Flags address errors on stores (ades), aligns legal stores into bus lanes
//   with byte enables, and queues them in a DEPTH-entry FIFO. The FIFO drains
//   to the data bus over valid/ready.
// Ports:
//   clk, reset (async, active low)
//   in_valid/in_addr/in_data/in_size/in_add_ovf : store from M stage
//   int_req  : kills the incoming store (queued entries still complete)
//   stall    : FIFO full, M stage must hold its store
//   ades     : combinational address-error-on-store
//   m_valid/m_ready/m_addr/m_wdata/m_byteen : bus request from FIFO head
//   empty    : no stores pending (fence condition)

// One byte lane: picks the source byte that lands on lane IDX and its enable.
module store_buffer_ext_lane #(
  parameter int NB  = 4,
  parameter int LW  = 2,
  parameter int IDX = 0
) (
  input  logic [LW-1:0]        lane,
  input  logic [3:0]           nbytes,
  input  logic [NB-1:0][7:0]   data,
  output logic                 be,
  output logic [7:0]           wbyte
);
  int off;

  always_comb begin
    off   = IDX - int'(lane);
    be    = (off >= 0) && (off < int'(nbytes));
    wbyte = 8'h00;
    // Bytes outside the store size stay zero (zero-extended field).
    if (be) wbyte = data[off[LW-1:0]];
  end
endmodule

module store_buffer_ext #(
  parameter int          DATA_W    = 32,
  parameter int          DEPTH     = 4,
  parameter logic [31:0] DM_START  = 32'h0000_0000,
  parameter logic [31:0] DM_END    = 32'h0000_2FFF,
  parameter logic [31:0] TC1_START = 32'h0000_7F00,
  parameter logic [31:0] TC2_START = 32'h0000_7F10,
  parameter logic [31:0] INT_START = 32'h0000_7F20,
  parameter logic [31:0] INT_END   = 32'h0000_7F23
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [31:0]           in_addr,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [1:0]            in_size,
  input  logic                  in_add_ovf,
  input  logic                  int_req,
  output logic                  stall,
  output logic                  ades,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [31:0]           m_addr,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_byteen,
  output logic                  empty
);
  localparam int NB = DATA_W / 8;
  localparam int LW = $clog2(NB);
  localparam int PW = $clog2(DEPTH);
  localparam bit IS32 = (DATA_W == 32);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic [NB-1:0]     be;
  } entry_t;

  // ---------------- address check ----------------
  logic [3:0] nbytes;
  logic       misaligned, out_of_range, timer_nonword, illegal_size;
  logic       in_dm, in_tc1, in_tc2, in_int, in_tc;

  always_comb begin
    case (in_size)
      2'b00:   nbytes = 4'd4;
      2'b01:   nbytes = 4'd2;
      2'b10:   nbytes = 4'd1;
      default: nbytes = 4'd8;
    endcase
  end

  // Offset-from-base compares avoid a constant ">= 0" when a region starts at 0.
  assign in_dm  = (in_addr - DM_START)  <= (DM_END - DM_START);
  assign in_tc1 = (in_addr - TC1_START) <= 32'd8;
  assign in_tc2 = (in_addr - TC2_START) <= 32'd8;
  assign in_int = (in_addr - INT_START) <= (INT_END - INT_START);
  assign in_tc  = in_tc1 | in_tc2;

  assign misaligned    = ((in_size == 2'b01) &  in_addr[0])
                       | ((in_size == 2'b00) & |in_addr[1:0])
                       | ((in_size == 2'b11) & |in_addr[2:0]);
  assign out_of_range  = ~(in_dm | in_tc | in_int);
  assign timer_nonword = in_tc & (in_size != 2'b00);
  assign illegal_size  = IS32 & (in_size == 2'b11);

  assign ades = in_valid & (misaligned | out_of_range | timer_nonword
                            | illegal_size | in_add_ovf);

  // ---------------- lane alignment ----------------
  logic [LW-1:0]         lane;
  logic [NB-1:0]         be_c;
  logic [NB-1:0][7:0]    wd_c;

  assign lane = in_addr[LW-1:0];

  for (genvar i = 0; i < NB; i++) begin : g_lane
    store_buffer_ext_lane #(.NB(NB), .LW(LW), .IDX(i)) u_lane (
      .lane   (lane),
      .nbytes (nbytes),
      .data   (in_data),
      .be     (be_c[i]),
      .wbyte  (wd_c[i])
    );
  end

  entry_t new_e;
  assign new_e.addr  = in_addr & ~32'(NB - 1);
  assign new_e.wdata = wd_c;
  assign new_e.be    = be_c;

  // ---------------- FIFO ----------------
  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          enq, deq;

  assign stall   = (count == FULL);   // no bypass when full
  assign empty   = (count == '0);
  assign m_valid = ~empty;
  assign enq     = in_valid & ~ades & ~int_req & ~stall;
  assign deq     = m_valid & m_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= new_e;
  end

  entry_t head;
  assign head     = mem[rd_ptr];
  assign m_addr   = m_valid ? head.addr  : '0;
  assign m_wdata  = m_valid ? head.wdata : '0;
  assign m_byteen = m_valid ? head.be    : '0;
endmodule
